// File: rtl/alu_result_buffer.sv
// First-word-fall-through result buffer for the ALU datapath, with a sticky overflow bit.
// Optional build macro ALU_BUF_OVFCNT_EN adds a saturating 8-bit overflow counter output (ovfCount).
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     zeroIn,
  input  logic                     overflowIn,
  input  logic                     carryoutIn,
  input  logic                     negativeIn,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     zeroFlag,
  output logic                     overflowFlag,
  output logic                     carryoutFlag,
  output logic                     negativeFlag,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clearSticky,
  output logic                     stickyOverflow
`ifdef ALU_BUF_OVFCNT_EN
  ,
  output logic [7:0]               ovfCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] memData_q  [DEPTH];
  logic [3:0]       memFlags_q [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_q, sticky_d;
  logic          push, pop;
  logic          pushOvf;
  logic [WIDTH-1:0] headData;
  logic [3:0]       headFlags;

  // Handshake is derived from registered occupancy only, so there is no in-to-out path.
  assign inReady  = (count_q < CW'(DEPTH));
  assign outValid = (count_q != '0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;
  assign pushOvf  = push && overflowIn;

  always_comb begin
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (push) wrPtr_d = wrPtr_q + AW'(1);
    if (pop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new overflow beats a same-cycle clear so no event is lost.
    if (pushOvf)          sticky_d = 1'b1;
    else if (clearSticky) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      memData_q[wrPtr_q]  <= dataIn;
      memFlags_q[wrPtr_q] <= {zeroIn, overflowIn, carryoutIn, negativeIn};
    end
  end

  assign headData  = memData_q[rdPtr_q];
  assign headFlags = memFlags_q[rdPtr_q];

  always_comb begin
    dataOut      = '0;
    zeroFlag     = 1'b0;
    overflowFlag = 1'b0;
    carryoutFlag = 1'b0;
    negativeFlag = 1'b0;
    if (outValid) begin
      dataOut      = headData;
      zeroFlag     = headFlags[3];
      overflowFlag = headFlags[2];
      carryoutFlag = headFlags[1];
      negativeFlag = headFlags[0];
    end
  end

  assign count          = count_q;
  assign stickyOverflow = sticky_q;

`ifdef ALU_BUF_OVFCNT_EN
  logic [7:0] ovfCount_q, ovfCount_d;

  always_comb begin
    ovfCount_d = ovfCount_q;
    if (pushOvf) begin
      if (clearSticky)               ovfCount_d = 8'd1;
      else if (ovfCount_q != 8'hFF)  ovfCount_d = ovfCount_q + 8'd1;
    end else if (clearSticky) begin
      ovfCount_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovfCount_q <= 8'd0;
    else       ovfCount_q <= ovfCount_d;
  end

  assign ovfCount = ovfCount_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_alu_result_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk;
  logic             reset;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] dataIn;
  logic             zeroIn, overflowIn, carryoutIn, negativeIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] dataOut;
  logic             zeroFlag, overflowFlag, carryoutFlag, negativeFlag;
  logic [$clog2(DEPTH):0] count;
  logic             clearSticky;
  logic             stickyOverflow;
`ifdef ALU_BUF_OVFCNT_EN
  logic [7:0]       ovfCount;
`endif

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .inValid        (inValid),
    .inReady        (inReady),
    .dataIn         (dataIn),
    .zeroIn         (zeroIn),
    .overflowIn     (overflowIn),
    .carryoutIn     (carryoutIn),
    .negativeIn     (negativeIn),
    .outValid       (outValid),
    .outReady       (outReady),
    .dataOut        (dataOut),
    .zeroFlag       (zeroFlag),
    .overflowFlag   (overflowFlag),
    .carryoutFlag   (carryoutFlag),
    .negativeFlag   (negativeFlag),
    .count          (count),
    .clearSticky    (clearSticky),
    .stickyOverflow (stickyOverflow)
`ifdef ALU_BUF_OVFCNT_EN
    ,
    .ovfCount       (ovfCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {word, zero, overflow, carryout, negative}.
  logic [WIDTH+3:0] modelQ [$];
  logic             modelSticky;
  int               modelOvfCnt;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [WIDTH+3:0] head;
    head = (modelQ.size() != 0) ? modelQ[0] : '0;
    checkOutput({tag, ".outValid"}, 64'(outValid), 64'(modelQ.size() != 0));
    checkOutput({tag, ".inReady"},  64'(inReady),  64'(modelQ.size() < DEPTH));
    checkOutput({tag, ".count"},    64'(count),    64'(modelQ.size()));
    checkOutput({tag, ".dataOut"},  64'(dataOut),  64'(head[WIDTH+3:4]));
    checkOutput({tag, ".flags"},
                64'({zeroFlag, overflowFlag, carryoutFlag, negativeFlag}), 64'(head[3:0]));
    checkOutput({tag, ".sticky"},   64'(stickyOverflow), 64'(modelSticky));
`ifdef ALU_BUF_OVFCNT_EN
    checkOutput({tag, ".ovfCount"}, 64'(ovfCount), 64'(modelOvfCnt));
`endif
  endtask

  // One clock cycle: drive inputs, check state before the edge, then advance the model.
  // flags order is {zero, overflow, carryout, negative}.
  task automatic applyStimulus(input string tag, input logic iv, input logic [WIDTH-1:0] d,
                               input logic [3:0] flags, input logic ordy, input logic clr);
    bit doPush, doPop;
    inValid     = iv;
    dataIn      = d;
    {zeroIn, overflowIn, carryoutIn, negativeIn} = flags;
    outReady    = ordy;
    clearSticky = clr;
    @(negedge clk);
    checkAll(tag);
    doPush = iv && (modelQ.size() < DEPTH);
    doPop  = ordy && (modelQ.size() != 0);
    @(posedge clk);
    if (doPop) void'(modelQ.pop_front());
    if (doPush) modelQ.push_back({d, flags});
    if (clr) begin
      modelSticky = 1'b0;
      modelOvfCnt = 0;
    end
    if (doPush && flags[2]) begin
      modelSticky = 1'b1;
      if (modelOvfCnt < 255) modelOvfCnt++;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic clearModel();
    modelQ.delete();
    modelSticky = 1'b0;
    modelOvfCnt = 0;
  endtask

  initial begin
    reset = 1'b1; inValid = 1'b0; dataIn = '0; outReady = 1'b0; clearSticky = 1'b0;
    {zeroIn, overflowIn, carryoutIn, negativeIn} = 4'b0000;
    clearModel();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    idle("reset");
    applyStimulus("push5", 1'b1, 32'h0000_0005, 4'b0000, 1'b0, 1'b0);
    applyStimulus("pop5",  1'b0, '0, 4'b0000, 1'b1, 1'b0);

    // Fill, hold a third push while full, then drain in order.
    applyStimulus("pushA",   1'b1, 32'hAAAA_0001, 4'b0010, 1'b0, 1'b0);
    applyStimulus("push0",   1'b1, 32'h0000_0000, 4'b1000, 1'b0, 1'b0);
    applyStimulus("hold1",   1'b1, 32'h0000_1234, 4'b0000, 1'b0, 1'b0);
    applyStimulus("hold2",   1'b1, 32'h0000_1234, 4'b0000, 1'b0, 1'b0);
    applyStimulus("fullPop", 1'b1, 32'h0000_1234, 4'b0000, 1'b1, 1'b0);
    applyStimulus("accept",  1'b1, 32'h0000_1234, 4'b0000, 1'b1, 1'b0);
    applyStimulus("drain1",  1'b0, '0, 4'b0000, 1'b1, 1'b0);

    // Simultaneous push and pop at count=1.
    applyStimulus("push7",   1'b1, 32'd7, 4'b0000, 1'b0, 1'b0);
    applyStimulus("pp9",     1'b1, 32'd9, 4'b0001, 1'b1, 1'b0);
    applyStimulus("drain2",  1'b0, '0, 4'b0000, 1'b1, 1'b0);

    // Sticky overflow set, survives pop, clear alone, clear versus set.
    applyStimulus("ovfPush", 1'b1, 32'h8000_0000, 4'b0100, 1'b0, 1'b0);
    applyStimulus("ovfPop",  1'b0, '0, 4'b0000, 1'b1, 1'b0);
    applyStimulus("clrOnly", 1'b0, '0, 4'b0000, 1'b0, 1'b1);
    applyStimulus("clrSet",  1'b1, 32'h7FFF_FFFF, 4'b0101, 1'b1, 1'b1);
    applyStimulus("drain3",  1'b0, '0, 4'b0000, 1'b1, 1'b0);

    // Asynchronous reset between edges with a full buffer.
    applyStimulus("fillA",   1'b1, 32'h1111_1111, 4'b0100, 1'b0, 1'b0);
    applyStimulus("fillB",   1'b1, 32'h2222_2222, 4'b0010, 1'b0, 1'b0);
    inValid = 1'b0;
    #2 reset = 1'b1;
    #1;
    clearModel();
    checkAll("midReset");
    #1 reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus("push3",   1'b1, 32'h0000_0003, 4'b0000, 1'b0, 1'b0);
    applyStimulus("alone3",  1'b0, '0, 4'b0000, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] f;
      f = 4'($urandom);
      f[2] = ($urandom_range(0, 9) < 3);
      applyStimulus("rand", ($urandom_range(0, 9) < 7), $urandom, f,
                    ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) == 0));
    end
    idle("randEnd");

`ifdef ALU_BUF_OVFCNT_EN
    applyStimulus("satClr", 1'b0, '0, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++)
      applyStimulus("sat", 1'b1, 32'(i), 4'b0100, 1'b1, 1'b0);
    idle("satDone");
    checkOutput("satValue", 64'(ovfCount), 64'd255);
    applyStimulus("satClear", 1'b0, '0, 4'b0000, 1'b1, 1'b1);
    idle("afterClear");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 32-bit ALU/compare datapath.
- Captures each ALU result word and its four status flags (zero, overflow, carryout, negative) into a small first-word-fall-through FIFO.
- Presents the results to the writeback/branch logic over a valid/ready handshake.
- Keeps a sticky overflow status bit for the control unit.

Parameters:
- WIDTH, 32, result word width.
- DEPTH, 2, number of entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- inValid  input  1  ALU result and flags present this cycle
- inReady  output  1  buffer can accept a push this cycle
- dataIn  input  WIDTH  ALU result word
- zeroIn, overflowIn, carryoutIn, negativeIn  input  1 each  ALU flags accompanying dataIn
- outValid  output  1  head entry is valid
- outReady  input  1  consumer accepts head entry this cycle
- dataOut  output  WIDTH  head entry result word
- zeroFlag, overflowFlag, carryoutFlag, negativeFlag  output  1 each  head entry flags
- count  output  $clog2(DEPTH)+1  number of occupied entries
- clearSticky  input  1  clears stickyOverflow (and the overflow counter, if compiled in)
- stickyOverflow  output  1  set once any pushed entry had overflowIn=1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high, and takes effect immediately.
- Reset values:
  - count=0; read and write pointers=0; stickyOverflow=0; outValid=0.
  - dataOut and all flag outputs = 0.
  - Storage contents are don't-care.
- Handshake rules:
  - push = inValid && inReady.
  - pop = outValid && outReady.
  - inReady = (count < DEPTH), purely from registered state. There is no combinational in→out pass-through.
  - outValid = (count != 0).
- Latency: an entry pushed at edge N is visible on dataOut/flags with outValid=1 after edge N (one-cycle latency), including when the buffer was empty.
- Ordering: strict FIFO; each entry stores {dataIn, zeroIn, overflowIn, carryoutIn, negativeIn} as one unit, and flags never separate from their word.
- Output gating: when outValid=0, dataOut and all flag outputs are driven to 0, never stale data.
- Pointers: wrap modulo DEPTH. count is updated as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full: inReady=0. A push is refused even if a pop happens the same cycle; the producer must hold inValid and data stable until accepted.
- Empty: a pop cannot occur (outValid=0). outReady is ignored.
- Sticky overflow:
  - Set on any push with overflowIn=1; cleared by clearSticky.
  - If set and clear occur in the same cycle, set wins (result 1).
  - Independent of pops.
- Reset mid-operation: all entries are discarded immediately and outputs return to reset values without waiting for a clock edge.
- Inputs are sampled only on cycles where a push occurs.

Optional Feature:
- Macro: ALU_BUF_OVFCNT_EN.
- Defined:
  - Adds output ovfCount [7:0], reset 0.
  - Increments on each push with overflowIn=1, saturating at 8'hFF.
  - clearSticky zeroes it. Increment has priority on a same-cycle conflict, giving result 1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then push dataIn=32'h0000_0005 with zeroIn=0 → next cycle outValid=1, dataOut=5, all flags 0, count=1, inReady=1.
- Push 32'hAAAA_0001 (carryoutIn=1), then 32'h0000_0000 (zeroIn=1) with outReady=0 → count=2, inReady=0. A third push of 32'h1234 is held and not accepted. Raise outReady → head pops in order AAAA_0001/carry=1 then 0000_0000/zero=1, and 1234 is accepted when count drops to 1.
- With count=1, push and pop in the same cycle (WIDTH-bit values 7 then 9) → count stays 1; dataOut changes from 7 to 9 after the edge; no loss or duplication.
- Push with overflowIn=1 → stickyOverflow=1 and it stays set after the pop. Assert clearSticky alone → 0. Assert clearSticky together with another overflow push → stays 1.
- Fill the buffer to count=2, then pulse reset between clock edges → outValid, count and stickyOverflow go to 0 immediately; dataOut=0; the subsequent push of 32'h3 appears alone.
- ALU_BUF_OVFCNT_EN: 300 pushes with overflowIn=1 → ovfCount saturates at 255; clearSticky → 0.
